// File: rtl/mem_stream_writer_if.sv
// Merged-stream input and memory-write / count-publish outputs of the stream writer.
// stream_valid / stream_hdr qualify stream_dat in the cycle they are high; there is no backpressure.
interface mem_stream_writer_if #(
  parameter int NMEM = 12,
  parameter int DW   = 45,
  parameter int AW   = 6,
  parameter int BXW  = 3,
  parameter int SW   = 54
);
  logic [SW-1:0]       stream_dat;
  logic                stream_valid;
  logic                stream_hdr;
  logic [NMEM-1:0]     we;
  logic [BXW+AW-1:0]   waddr;
  logic [DW-1:0]       wdata;
  logic [NMEM*AW-1:0]  number_out;
  logic [BXW-1:0]      bx_out;
  logic                nums_valid;
  logic [NMEM-1:0]     ovf;
  logic                err;

  modport master (
    output stream_dat, stream_valid, stream_hdr,
    input  we, waddr, wdata, number_out, bx_out, nums_valid, ovf, err
  );

  modport slave (
    input  stream_dat, stream_valid, stream_hdr,
    output we, waddr, wdata, number_out, bx_out, nums_valid, ovf, err
  );
endinterface

// File: rtl/mem_stream_writer.sv
// Demultiplexes the merged readout stream into NMEM BX-paged memories and
// publishes per-memory item counts at every BX boundary.
module mem_stream_writer #(
  parameter int NMEM = 12,
  parameter int DW   = 45,
  parameter int AW   = 6,
  parameter int BXW  = 3,
  parameter int SW   = 54
) (
  input  logic               clk,
  input  logic               reset,
  mem_stream_writer_if.slave bus,
  output logic               dbg_state_o
);

  localparam int TW = 4;
  localparam logic [AW-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [AW-1:0]        cnt_q [NMEM];
  logic [AW-1:0]        cnt_d [NMEM];
  logic [BXW-1:0]       cur_bx_q, cur_bx_d;
  logic [NMEM-1:0]      we_q, we_d;
  logic [BXW+AW-1:0]    waddr_q, waddr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [NMEM*AW-1:0]   number_q, number_d;
  logic [BXW-1:0]       bx_out_q, bx_out_d;
  logic                 nums_valid_q, nums_valid_d;
  logic [NMEM-1:0]      ovf_q, ovf_d;
  logic                 err_q, err_d;

  logic [TW-1:0]        tag;
  logic                 unused_dat;

  assign tag        = bus.stream_dat[SW-1 -: TW];
  assign unused_dat = ^bus.stream_dat[SW-TW-1:DW];

  always_comb begin
    state_d      = state_q;
    cur_bx_d     = cur_bx_q;
    cnt_d        = cnt_q;
    we_d         = '0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    number_d     = number_q;
    bx_out_d     = bx_out_q;
    nums_valid_d = 1'b0;
    ovf_d        = ovf_q;
    err_d        = err_q;

    if (bus.stream_hdr) begin
      // cnt_q already includes a write issued by the word in the previous cycle
      if (state_q == RECV) begin
        for (int i = 0; i < NMEM; i++) number_d[i*AW +: AW] = cnt_q[i];
        bx_out_d     = cur_bx_q;
        nums_valid_d = 1'b1;
      end
      state_d  = RECV;
      cur_bx_d = bus.stream_dat[BXW-1:0];
      for (int i = 0; i < NMEM; i++) cnt_d[i] = '0;
      ovf_d = '0;
      if (bus.stream_valid) err_d = 1'b1;
    end else if (bus.stream_valid && state_q == RECV) begin
      if (int'(tag) >= NMEM) begin
        err_d = 1'b1;
      end else begin
        for (int k = 0; k < NMEM; k++) begin
          if (tag == TW'(k)) begin
            if (cnt_q[k] == CNT_MAX) begin
              ovf_d[k] = 1'b1;
            end else begin
              we_d[k]  = 1'b1;
              waddr_d  = {cur_bx_q, cnt_q[k]};
              wdata_d  = bus.stream_dat[DW-1:0];
              cnt_d[k] = cnt_q[k] + 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      for (int i = 0; i < NMEM; i++) cnt_q[i] <= '0;
      cur_bx_q     <= '0;
      we_q         <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      number_q     <= '0;
      bx_out_q     <= '0;
      nums_valid_q <= 1'b0;
      ovf_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cur_bx_q     <= cur_bx_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      number_q     <= number_d;
      bx_out_q     <= bx_out_d;
      nums_valid_q <= nums_valid_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
    end
  end

  assign bus.we         = we_q;
  assign bus.waddr      = waddr_q;
  assign bus.wdata      = wdata_q;
  assign bus.number_out = number_q;
  assign bus.bx_out     = bx_out_q;
  assign bus.nums_valid = nums_valid_q;
  assign bus.ovf        = ovf_q;
  assign bus.err        = err_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_mem_stream_writer.sv
// Directed bench for mem_stream_writer: expected writes and publishes are queued
// by the stimulus and consumed by an independent output monitor.
module tb_mem_stream_writer;
  localparam int NMEM = 12;
  localparam int DW   = 45;
  localparam int AW   = 6;
  localparam int BXW  = 3;
  localparam int SW   = 54;

  logic clk;
  logic reset;
  logic dbg_state;

  mem_stream_writer_if #(.NMEM(NMEM), .DW(DW), .AW(AW), .BXW(BXW), .SW(SW)) bus ();

  mem_stream_writer #(.NMEM(NMEM), .DW(DW), .AW(AW), .BXW(BXW), .SW(SW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // scoreboard: write entries {tag, waddr, wdata}, publish entries {bx, counts}
  logic [4+BXW+AW+DW-1:0] exp_q[$];
  logic [BXW+NMEM*AW-1:0] pub_q[$];
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [SW-1:0] mkword(input int tag, input logic [DW-1:0] pl);
    logic [3:0] t;
    t = 4'(tag);
    return {t, 5'b0, pl};
  endfunction

  function automatic logic [SW-1:0] mkhdr(input int bx);
    logic [BXW-1:0] b;
    b = BXW'(bx);
    return {{(SW-BXW){1'b0}}, b};
  endfunction

  function automatic logic [DW-1:0] pl(input int i);
    return DW'(64'h0ABC_0000 + 64'(i));
  endfunction

  function automatic logic [NMEM*AW-1:0] cnts(input int t0, input int v0, input int t1, input int v1);
    logic [NMEM*AW-1:0] r;
    r = '0;
    if (t0 >= 0) r[t0*AW +: AW] = AW'(v0);
    if (t1 >= 0) r[t1*AW +: AW] = AW'(v1);
    return r;
  endfunction

  // driver tasks
  task automatic drive(input logic [SW-1:0] d, input logic v, input logic h);
    @(negedge clk);
    bus.stream_dat   = d;
    bus.stream_valid = v;
    bus.stream_hdr   = h;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, 1'b0, 1'b0);
  endtask

  task automatic exp_wr(input int tag, input logic [BXW+AW-1:0] addr, input logic [DW-1:0] d);
    exp_q.push_back({4'(tag), addr, d});
  endtask

  task automatic exp_pub(input int bx, input logic [NMEM*AW-1:0] c);
    pub_q.push_back({BXW'(bx), c});
  endtask

  // monitor
  always @(negedge clk) begin
    if (reset) begin
      logic [3:0] wtag;
      wtag = '0;
      for (int i = 0; i < NMEM; i++) if (bus.we[i]) wtag = 4'(i);
      if (bus.we != '0) begin
        chk("we_onehot", 128'($onehot(bus.we)), 128'(1));
        if (exp_q.size() == 0) chk("unexpected_write", 128'(bus.we), 128'(0));
        else chk("write", 128'({wtag, bus.waddr, bus.wdata}), 128'(exp_q.pop_front()));
      end
      if (bus.nums_valid) begin
        if (pub_q.size() == 0) chk("unexpected_publish", 128'(bus.nums_valid), 128'(0));
        else chk("publish", 128'({bus.bx_out, bus.number_out}), 128'(pub_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b0;
    bus.stream_dat   = '0;
    bus.stream_valid = 1'b0;
    bus.stream_hdr   = 1'b0;
    idle(2);
    chk("rst_we",     128'(bus.we), 128'(0));
    chk("rst_waddr",  128'(bus.waddr), 128'(0));
    chk("rst_number", 128'(bus.number_out), 128'(0));
    chk("rst_misc",   128'({bus.bx_out, bus.nums_valid, bus.ovf, bus.err, dbg_state}), 128'(0));
    @(negedge clk);
    reset = 1'b1;

    // words before any header are ignored, first header publishes nothing
    drive(mkword(0, pl(1)), 1'b1, 1'b0);
    drive(mkword(0, pl(2)), 1'b1, 1'b0);
    drive(mkword(13, pl(3)), 1'b1, 1'b0);
    idle(1);
    chk("idle_err", 128'(bus.err), 128'(0));
    chk("idle_state", 128'(dbg_state), 128'(0));

    // BX 5, three words on tag 2
    drive(mkhdr(5), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      exp_wr(2, 9'h140 + 9'(i), pl(10 + i));
      drive(mkword(2, pl(10 + i)), 1'b1, 1'b0);
    end
    idle(1);
    chk("recv_state", 128'(dbg_state), 128'(1));
    exp_pub(5, cnts(2, 3, -1, 0));
    drive(mkhdr(6), 1'b0, 1'b1);

    // BX 6: interleaved tags, header right after the last word
    exp_wr(0, 9'h180, pl(20)); drive(mkword(0, pl(20)), 1'b1, 1'b0);
    exp_wr(11, 9'h180, pl(21)); drive(mkword(11, pl(21)), 1'b1, 1'b0);
    exp_wr(0, 9'h181, pl(22)); drive(mkword(0, pl(22)), 1'b1, 1'b0);
    exp_pub(6, cnts(0, 2, 11, 1));
    drive(mkhdr(1), 1'b0, 1'b1);

    // BX 1: tag 7 saturates at 63 items
    for (int i = 0; i < 70; i++) begin
      if (i < 63) exp_wr(7, 9'h040 + 9'(i), pl(100 + i));
      drive(mkword(7, pl(100 + i)), 1'b1, 1'b0);
    end
    idle(2);
    chk("ovf_set", 128'(bus.ovf), 128'(12'h080));
    chk("err_clean", 128'(bus.err), 128'(0));
    exp_pub(1, cnts(7, 63, -1, 0));
    drive(mkhdr(2), 1'b0, 1'b1);
    idle(2);
    chk("ovf_cleared", 128'(bus.ovf), 128'(0));

    // repeated BX value still publishes (empty counts)
    exp_pub(2, cnts(-1, 0, -1, 0));
    drive(mkhdr(2), 1'b0, 1'b1);
    idle(1);

    // bad tag sets err
    drive(mkword(13, pl(200)), 1'b1, 1'b0);
    idle(1);
    chk("err_bad_tag", 128'(bus.err), 128'(1));

    // header and data together: header wins, word dropped
    exp_pub(2, cnts(-1, 0, -1, 0));
    drive(mkword(2, pl(201)) | mkhdr(3), 1'b1, 1'b1);
    exp_wr(4, 9'h0C0, pl(202)); drive(mkword(4, pl(202)), 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      exp_wr(4, 9'h0C0 + 9'(i), pl(202 + i));
      drive(mkword(4, pl(202 + i)), 1'b1, 1'b0);
    end
    idle(2);
    chk("err_sticky", 128'(bus.err), 128'(1));

    // asynchronous reset mid-BX
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_outputs", 128'({bus.we, bus.waddr, bus.wdata}), 128'(0));
    chk("mid_rst_status",  128'({bus.number_out, bus.bx_out, bus.nums_valid, bus.ovf, bus.err, dbg_state}), 128'(0));
    idle(2);
    reset = 1'b1;

    // first header after reset does not publish, counters restart at 0
    drive(mkhdr(7), 1'b0, 1'b1);
    exp_wr(1, 9'h1C0, pl(300)); drive(mkword(1, pl(300)), 1'b1, 1'b0);
    exp_pub(7, cnts(1, 1, -1, 0));
    drive(mkhdr(0), 1'b0, 1'b1);
    idle(3);
    chk("exp_q_drained", 128'(exp_q.size()), 128'(0));
    chk("pub_q_drained", 128'(pub_q.size()), 128'(0));

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
